ex_muldiv: RTL and testbench

//  EX-stage iterative multiply/divide unit, fed directly by the ID/EX register outputs.

---
 rtl/ex_muldiv.sv | 147 ++++++++++++++
 tb/tb_ex_muldiv.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
// Ports: clk, rst_n (async, active low); EX_start/EX_op/EX_rdata1/EX_rdata2 start an op;
// EX_hi_we/EX_lo_we perform MTHI/MTLO; EX_mf_req flags MFHI/MFLO in EX;
// hi/lo registers, busy, done (1-cycle pulse), stall (combinational).
module ex_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EX_start,
  input  logic [1:0]       EX_op,
  input  logic [WIDTH-1:0] EX_rdata1,
  input  logic [WIDTH-1:0] EX_rdata2,
  input  logic             EX_hi_we,
  input  logic             EX_lo_we,
  input  logic             EX_mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_neg    = ~EX_op[0] & EX_rdata1[WIDTH-1];
    b_neg    = ~EX_op[0] & EX_rdata2[WIDTH-1];
    a_mag    = a_neg ? -EX_rdata1 : EX_rdata1;
    b_mag    = b_neg ? -EX_rdata2 : EX_rdata2;
    // p_q is shared: MUL keeps {accumulator, multiplier}, DIV keeps {remainder, dividend/quotient}
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? b_q : {WIDTH{1'b0}})};
    div_diff = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    prod     = neg_q ? -p_q : p_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (EX_hi_we) hi_d = EX_rdata1;
        if (EX_lo_we) lo_d = EX_rdata1;
        if (EX_start) begin
          state_d = EX_op[1] ? S_DIV : S_MUL;
          cnt_d   = '0;
          div_d   = EX_op[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          if (EX_op[1]) begin
            p_d = {{WIDTH{1'b0}}, a_mag};
            b_d = b_mag;
          end else begin
            p_d = {{WIDTH{1'b0}}, b_mag};
            b_d = a_mag;
          end
        end
      end
      S_MUL: begin
        p_d   = {mul_sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_DIV: begin
        if (div_diff[WIDTH]) p_d = {p_q[2*WIDTH-2:0], 1'b0};
        else                 p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (div_q) begin
          // divide by zero leaves |rs| as remainder; re-signing it restores rs exactly
          lo_d = (b_q == '0) ? '1 : (neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
          hi_d = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = busy & (EX_start | EX_hi_we | EX_lo_we | EX_mf_req);

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_start, EX_hi_we, EX_lo_we, EX_mf_req;
  logic [1:0]  EX_op;
  logic [31:0] EX_rdata1, EX_rdata2;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .EX_start(EX_start), .EX_op(EX_op),
    .EX_rdata1(EX_rdata1), .EX_rdata2(EX_rdata2), .EX_hi_we(EX_hi_we),
    .EX_lo_we(EX_lo_we), .EX_mf_req(EX_mf_req), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, q, r;
    logic        [63:0] ua, ub;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    case (op)
      2'b00: model = sa * sb64;
      2'b01: model = ua * ub;
      2'b10: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb64;
          r = sa % sb64;
          model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else model = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit hold_mf, input bit lo_we_mid);
    int unsigned n;
    logic [63:0] e;
    @(negedge clk);
    EX_op = op; EX_rdata1 = a; EX_rdata2 = b; EX_start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    EX_start  = 1'b0;
    EX_mf_req = hold_mf;
    n = 0;
    while (!done && n < 100) begin
      if (busy) n++;
      if (hold_mf) check("stall_busy", {63'h0, stall}, 64'h1);
      if (lo_we_mid && n == 5) begin
        EX_lo_we  = 1'b1;
        EX_rdata1 = 32'hDEAD_BEEF;
      end else EX_lo_we = 1'b0;
      @(negedge clk);
    end
    EX_lo_we = 1'b0;
    check("done_pulse", {63'h0, done}, 64'h1);
    check("busy_low", {63'h0, busy}, 64'h0);
    check("busy_cycles", 64'(n), 64'd33);
    if (hold_mf) check("stall_done", {63'h0, stall}, 64'h0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("hi", {32'h0, hi}, {32'h0, e[63:32]});
      check("lo", {32'h0, lo}, {32'h0, e[31:0]});
    end else check("sb_empty", 64'(sb.size()), 64'd1);
    EX_mf_req = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {63'h0, done}, 64'h0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    EX_start = 1'b0; EX_hi_we = 1'b0; EX_lo_we = 1'b0; EX_mf_req = 1'b0;
    EX_op = 2'b00; EX_rdata1 = '0; EX_rdata2 = '0;
    #12;
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    check("rst_busy_done_stall", {61'h0, busy, done, stall}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI while idle
    @(negedge clk);
    EX_hi_we = 1'b1; EX_rdata1 = 32'h0000_ABCD;
    @(negedge clk);
    EX_hi_we = 1'b0;
    check("mthi", {32'h0, hi}, 64'h0000_ABCD);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 28);
      run_op(rop, ra, rb, model(rop, ra, rb), 1'b0, 1'b0);
    end

    run_op(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1, 1'b1);

    // asynchronous reset mid-operation
    @(negedge clk);
    EX_op = 2'b00; EX_rdata1 = 32'h1234_5678; EX_rdata2 = 32'h9ABC_DEF0; EX_start = 1'b1;
    @(negedge clk);
    EX_start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", {63'h0, busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", {32'h0, hi}, 64'h0);
    check("arst_lo", {32'h0, lo}, 64'h0);
    check("arst_busy_done", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    EX_lo_we = 1'b1; EX_rdata1 = 32'h0000_1234;
    @(negedge clk);
    EX_lo_we = 1'b0;
    check("mtlo_after_rst", {32'h0, lo}, 64'h0000_1234);
    check("hi_after_rst", {32'h0, hi}, 64'h0);
    check("idle_after_rst", {62'h0, busy, done}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
